// File: rtl/nn_pkg.sv
// Shared neuron-datapath types: 17-bit activation format and its saturating helper.
package nn_pkg;

  localparam int ACT_W   = 17;
  localparam int ACT_MAX = 65535;
  localparam int ACT_MIN = -65536;

  typedef logic signed [ACT_W-1:0] act_t;

  typedef struct packed {
    act_t data;
    logic sat;
  } sat_res_t;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_t;

  // Round half up, shift arithmetic right, clip to the activation range.
  // 64 bits of headroom keeps the rounding add from wrapping for any sane accumulator.
  function automatic sat_res_t sat_act(input logic signed [63:0] wide, input int shift);
    logic signed [63:0] v;
    sat_res_t           r;
    v = wide;
    if (shift > 0) v = (v + (64'sd1 <<< (shift - 1))) >>> shift;
    r.sat  = 1'b0;
    r.data = v[ACT_W-1:0];
    if (v > 64'(ACT_MAX)) begin
      r.data = ACT_W'(ACT_MAX);
      r.sat  = 1'b1;
    end else if (v < 64'(ACT_MIN)) begin
      r.data = ACT_W'(ACT_MIN);
      r.sat  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/round_sat17.sv
// Combinational narrowing: round half up, arithmetic shift, clip to signed 17 bits.
module round_sat17
  import nn_pkg::*;
#(
  parameter int ACC_W = 22,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [ACT_W-1:0] res,
  output logic                    sat
);

  // One guard bit above the accumulator so the rounding add cannot wrap.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF =
    (SHIFT > 0) ? (RW'(1) <<< ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] shd;
  sat_res_t             clip;

  assign ext = RW'(sum);
  assign rnd = ext + HALF;
  assign shd = rnd >>> SHIFT;

  always_comb begin
    clip = sat_act(64'(shd), 0);
    res  = clip.data;
    sat  = clip.sat;
  end

endmodule

// File: rtl/acc_sat17.sv
// Frame accumulator: sums signed 17-bit terms, then rounds/shifts/saturates back to 17 bits.
module acc_sat17
  import nn_pkg::*;
#(
  parameter int N_TERMS = 16,
  parameter int ACC_W   = 22,
  parameter int SHIFT   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACT_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACT_W-1:0] out_data,
  output logic                    out_sat,
  output logic                    out_short
);

  localparam int CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  acc_state_t             state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    hs;
  logic                    frame_end;
  logic signed [ACT_W-1:0] r_data;
  logic                    r_sat;

  assign hs        = in_valid & in_ready;
  assign nxt       = acc + ACC_W'(in_data);
  assign frame_end = in_last | (cnt == LAST_CNT);

  round_sat17 #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_rnd (
    .sum (nxt),
    .res (r_data),
    .sat (r_sat)
  );

  // in_ready/out_valid are registered copies of the state; in_ready stays low
  // for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_short <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          in_ready <= 1'b1;
          if (hs) begin
            if (frame_end) begin
              out_data  <= r_data;
              out_sat   <= r_sat;
              out_short <= in_last && (cnt < LAST_CNT);
              acc       <= '0;
              cnt       <= '0;
              state     <= ST_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              acc <= nxt;
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sat17.sv
// Scoreboard bench: two instances (SHIFT=0 and SHIFT=2) share one input stream.
module tb_acc_sat17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic signed [16:0] in_data = '0;

  logic in_ready0, out_valid0, out_sat0, out_short0;
  logic in_ready2, out_valid2, out_sat2, out_short2;
  logic signed [16:0] out_data0, out_data2;

  typedef struct {
    int data;
    bit sat;
    bit shrt;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  acc_sat17 #(.N_TERMS(16), .ACC_W(22), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_sat(out_sat0), .out_short(out_short0)
  );

  acc_sat17 #(.N_TERMS(16), .ACC_W(22), .SHIFT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_sat(out_sat2), .out_short(out_short2)
  );

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic expect2(input int d0, input bit s0, input int d2, input bit s2, input bit sh);
    exp_t e;
    e.data = d0; e.sat = s0; e.shrt = sh; q0.push_back(e);
    e.data = d2; e.sat = s2; e.shrt = sh; q2.push_back(e);
  endtask

  // Monitors: compare whenever a result handshake is about to happen.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL s0 unexpected result: got %0d, want none", out_data0);
      end else begin
        e = q0.pop_front();
        chk("s0 out_data", out_data0, e.data);
        chk("s0 out_sat", out_sat0, e.sat);
        chk("s0 out_short", out_short0, e.shrt);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid2 && out_ready) begin
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL s2 unexpected result: got %0d, want none", out_data2);
      end else begin
        e = q2.pop_front();
        chk("s2 out_data", out_data2, e.data);
        chk("s2 out_sat", out_sat2, e.sat);
        chk("s2 out_short", out_short2, e.shrt);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d, input bit last, input int gap);
    int n;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = 17'(d);
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) begin
      n_cmp++; n_bad++;
      $display("FAIL send timeout: in_ready=%b, want 1", in_ready0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result must appear one cycle after the closing handshake, with a single bubble.
  task automatic post_frame();
    @(negedge clk);
    chk("out_valid after last", out_valid0, 1);
    chk("s2 out_valid after last", out_valid2, 1);
    chk("bubble in_ready", in_ready0, 0);
    @(posedge clk);
    #1;
    chk("in_ready after out hs", in_ready0, 1);
    chk("out_valid after out hs", out_valid0, 0);
  endtask

  task automatic frame_const(input int v, input int n);
    for (int i = 0; i < n; i++) send(v, 1'b0, 0);
    post_frame();
  endtask

  task automatic refm(input longint s, input int sh, output int d, output bit sat);
    longint r;
    r = s;
    if (sh > 0) r = (s + (64'sd1 <<< (sh - 1))) >>> sh;
    sat = 1'b0;
    if (r > 65535) begin r = 65535; sat = 1'b1; end
    if (r < -65536) begin r = -65536; sat = 1'b1; end
    d = int'(r);
  endtask

  int vals[16] = '{12345, -40000, 65535, -3, 777, -65536, 30000, 30000,
                   30000, -1, 2, 65535, 65535, -12, 5, 100};
  int lens[4] = '{3, 4, 5, 16};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     d0, d2, idx;
    bit     s0, s2;
    longint sum;

    // Reset state
    #12;
    chk("rst out_valid", out_valid0, 0);
    chk("rst in_ready", in_ready0, 0);
    chk("rst out_data", out_data0, 0);
    chk("rst out_sat", out_sat0, 0);
    chk("rst out_short", out_short0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready before first edge", in_ready0, 0);
    @(posedge clk);
    #1;
    chk("in_ready one edge after reset", in_ready0, 1);

    // Full frames, closed by the term count
    expect2(16000, 0, 4000, 0, 0);
    frame_const(1000, 16);
    expect2(65535, 1, 65535, 1, 0);
    frame_const(65535, 16);
    expect2(-65536, 1, -65536, 1, 0);
    frame_const(-65536, 16);

    // Short frames and rounding
    expect2(7, 0, 2, 0, 1);
    send(5, 1'b0, 0);
    send(2, 1'b1, 0);
    post_frame();
    expect2(-7, 0, -2, 0, 1);
    send(-7, 1'b1, 0);
    post_frame();

    // Backpressure: result held, 999 refused until release
    out_ready = 1'b0;
    expect2(30, 0, 8, 0, 1);
    send(10, 1'b0, 0);
    send(20, 1'b1, 0);
    in_valid = 1'b1;
    in_data  = 17'sd999;
    in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold out_data", out_data0, 30);
      chk("hold s2 out_data", out_data2, 8);
      chk("hold out_valid", out_valid0, 1);
      chk("hold in_ready", in_ready0, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    expect2(1000, 0, 250, 0, 1);
    send(999, 1'b0, 0);
    send(1, 1'b1, 0);
    post_frame();

    // Frames with random input gaps against the reference model
    idx = 0;
    for (int f = 0; f < 4; f++) begin
      sum = 0;
      for (int i = 0; i < lens[f]; i++) sum += vals[(idx + i) % 16];
      refm(sum, 0, d0, s0);
      refm(sum, 2, d2, s2);
      expect2(d0, s0, d2, s2, lens[f] < 16);
      for (int i = 0; i < lens[f]; i++)
        send(vals[(idx + i) % 16], (i == lens[f] - 1) && (lens[f] < 16), int'($urandom_range(0, 3)));
      post_frame();
      idx += lens[f];
    end

    // Reset mid-frame discards the partial sum
    for (int i = 0; i < 7; i++) send(1, 1'b0, 0);
    rst_n = 1'b0;
    #2;
    chk("midrst out_valid", out_valid0, 0);
    chk("midrst in_ready", in_ready0, 0);
    chk("midrst out_data", out_data0, 0);
    chk("midrst out_sat", out_sat0, 0);
    chk("midrst out_short", out_short0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after midrst", in_ready0, 1);
    expect2(16, 0, 4, 0, 0);
    frame_const(1, 16);

    repeat (4) @(posedge clk);
    #1;
    chk("s0 queue drained", q0.size(), 0);
    chk("s2 queue drained", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
